decode_stage: RTL and testbench

Second stage of the pipelined MIPS core. Consumes the 64-bit IF/ID word from the fetch stage ({PC+4, instruction}) and performs all instruction-decode work: register-file read, control decode, immediate sign-extension and load-use hazard detection. Produces the registered 152-bit ID/EX word for the execute stage. Also accepts the write-back port into its internal register file.

---
 rtl/decode_stage.sv | 104 ++++++++++
 tb/tb_decode_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS ID stage: register file, control decode, immediate sign-extension and
// load-use hazard detection, producing the registered 152-bit ID/EX word.
module decode_stage (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   IF_ID,
    input  logic          wb_reg_write,
    input  logic [4:0]    wb_write_reg,
    input  logic [31:0]   wb_write_data,
    input  logic          flush,
    output logic          stall,
    output logic [151:0]  ID_EX
);
    localparam int DATA_W = 32;

    // {ALUOp[1:0], Branch, MemWrite, MemRead, RegWrite, MemtoReg, ALUSrc, RegDst}
    localparam logic [8:0] CTRL_RTYPE = 9'b10_0_0_0_1_0_0_1;
    localparam logic [8:0] CTRL_LW    = 9'b00_0_0_1_1_1_1_0;
    localparam logic [8:0] CTRL_SW    = 9'b00_0_1_0_0_0_1_0;
    localparam logic [8:0] CTRL_BEQ   = 9'b01_1_0_0_0_0_0_0;
    localparam logic [8:0] CTRL_ADDI  = 9'b00_0_0_0_1_0_1_0;

    logic [5:0]                opcode_p0;
    logic [4:0]                rs_p0;
    logic [4:0]                rt_p0;
    logic [4:0]                rd_p0;
    logic [DATA_W-1:0]         pc4_p0;
    logic signed [DATA_W-1:0]  imm_p0;
    logic [DATA_W-1:0]         rs_data_p0;
    logic [DATA_W-1:0]         rt_data_p0;
    logic [8:0]                ctrl_p0;
    logic                      load_use;
    logic                      wb_active;
    logic [151:0]              id_ex_p1;
    logic [DATA_W-1:0]         regs [32];

    function automatic logic signed [DATA_W-1:0] sign_ext16(input logic signed [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    // Stage 0: field extraction, register read with write-back bypass, control decode
    assign opcode_p0 = IF_ID[31:26];
    assign rs_p0     = IF_ID[25:21];
    assign rt_p0     = IF_ID[20:16];
    assign rd_p0     = IF_ID[15:11];
    assign pc4_p0    = IF_ID[63:32];
    assign imm_p0    = sign_ext16(IF_ID[15:0]);
    assign wb_active = wb_reg_write && (wb_write_reg != 5'd0);

    always_comb begin
        rs_data_p0 = regs[rs_p0];
        if (rs_p0 == 5'd0)
            rs_data_p0 = '0;
        else if (wb_active && (wb_write_reg == rs_p0))
            rs_data_p0 = wb_write_data;
    end

    always_comb begin
        rt_data_p0 = regs[rt_p0];
        if (rt_p0 == 5'd0)
            rt_data_p0 = '0;
        else if (wb_active && (wb_write_reg == rt_p0))
            rt_data_p0 = wb_write_data;
    end

    always_comb begin
        ctrl_p0 = '0;
        case (opcode_p0)
            6'b000000: ctrl_p0 = CTRL_RTYPE;
            6'b100011: ctrl_p0 = CTRL_LW;
            6'b101011: ctrl_p0 = CTRL_SW;
            6'b000100: ctrl_p0 = CTRL_BEQ;
            6'b001000: ctrl_p0 = CTRL_ADDI;
            default:   ctrl_p0 = '0;
        endcase
    end

    // A load sitting in EX whose rt feeds this instruction forces one bubble
    assign load_use = id_ex_p1[147] && (id_ex_p1[9:5] != 5'd0) &&
                      ((id_ex_p1[9:5] == rs_p0) || (id_ex_p1[9:5] == rt_p0));
    assign stall    = load_use && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_active) begin
            regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Stage 1: ID/EX register; flush takes priority over the load-use bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            id_ex_p1 <= '0;
        else if (flush || load_use)
            id_ex_p1 <= '0;
        else
            id_ex_p1 <= {ctrl_p0, pc4_p0, rs_data_p0, rt_data_p0, imm_p0,
                         rs_p0, rt_p0, rd_p0};
    end

    assign ID_EX = id_ex_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage, plus hand-written reset sequence.
module tb_decode_stage;
    logic          clk;
    logic          reset;
    logic [63:0]   IF_ID;
    logic          wb_reg_write;
    logic [4:0]    wb_write_reg;
    logic [31:0]   wb_write_data;
    logic          flush;
    logic          stall;
    logic [151:0]  ID_EX;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .IF_ID(IF_ID),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .flush(flush),
        .stall(stall), .ID_EX(ID_EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [63:0]  if_id;
        logic         wb_en;
        logic [4:0]   wb_reg;
        logic [31:0]  wb_data;
        logic         flush;
        logic         exp_stall;
        logic [151:0] exp_idex;
    } vec_t;

    localparam logic [8:0] C_R    = 9'b10_0_0_0_1_0_0_1;
    localparam logic [8:0] C_LW   = 9'b00_0_0_1_1_1_1_0;
    localparam logic [8:0] C_SW   = 9'b00_0_1_0_0_0_1_0;
    localparam logic [8:0] C_BEQ  = 9'b01_1_0_0_0_0_0_0;
    localparam logic [8:0] C_ADDI = 9'b00_0_0_0_1_0_1_0;

    localparam logic [31:0] I_ADD   = 32'h01095020; // add $10,$8,$9
    localparam logic [31:0] I_ADD7  = 32'h00E95020; // add $10,$7,$9
    localparam logic [31:0] I_LW    = 32'h8D280004; // lw $8,4($9)
    localparam logic [31:0] I_SW    = 32'hAD280008; // sw $8,8($9)
    localparam logic [31:0] I_BEQ   = 32'h11090003; // beq $8,$9,3
    localparam logic [31:0] I_ADDI  = 32'h2001FFFF; // addi $1,$0,-1
    localparam logic [31:0] I_ADD0  = 32'h00001020; // add $2,$0,$0
    localparam logic [31:0] I_ILL   = 32'hFC221820; // opcode 111111

    function automatic logic [151:0] mk(input logic [8:0] c, input logic [31:0] pc4,
                                        input logic [31:0] rsd, input logic [31:0] rtd,
                                        input logic [31:0] imm, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
        return {c, pc4, rsd, rtd, imm, rs, rt, rd};
    endfunction

    function automatic vec_t v(input string n, input logic [31:0] pc4, input logic [31:0] ins,
                               input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic fl, input logic st, input logic [151:0] ex);
        vec_t r;
        r.name = n; r.if_id = {pc4, ins}; r.wb_en = we; r.wb_reg = wr; r.wb_data = wd;
        r.flush = fl; r.exp_stall = st; r.exp_idex = ex;
        return r;
    endfunction

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic chkw(input string n, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    vec_t vecs[20];

    initial begin
        vecs[0]  = v("illegal_op", 32'h40, I_ILL, 1, 5'd8, 32'hAA, 0, 0,
                     mk(9'd0, 32'h40, 0, 0, 32'h1820, 5'd1, 5'd2, 5'd3));
        vecs[1]  = v("rtype_bypass_rt", 32'h44, I_ADD, 1, 5'd9, 32'h55, 0, 0,
                     mk(C_R, 32'h44, 32'hAA, 32'h55, 32'h5020, 5'd8, 5'd9, 5'd10));
        vecs[2]  = v("bypass_rs", 32'h48, I_ADD, 1, 5'd8, 32'h1234, 0, 0,
                     mk(C_R, 32'h48, 32'h1234, 32'h55, 32'h5020, 5'd8, 5'd9, 5'd10));
        vecs[3]  = v("addi_wr0", 32'h4C, I_ADDI, 1, 5'd0, 32'hFFFF, 0, 0,
                     mk(C_ADDI, 32'h4C, 0, 0, 32'hFFFFFFFF, 5'd0, 5'd1, 5'd31));
        vecs[4]  = v("read_r0", 32'h50, I_ADD0, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_R, 32'h50, 0, 0, 32'h1020, 5'd0, 5'd0, 5'd2));
        vecs[5]  = v("lw", 32'h54, I_LW, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_LW, 32'h54, 32'h55, 32'h1234, 32'h4, 5'd9, 5'd8, 5'd0));
        vecs[6]  = v("loaduse_stall", 32'h58, I_ADD, 0, 5'd0, 32'h0, 0, 1, '0);
        vecs[7]  = v("after_stall", 32'h58, I_ADD, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_R, 32'h58, 32'h1234, 32'h55, 32'h5020, 5'd8, 5'd9, 5'd10));
        vecs[8]  = v("lw2", 32'h5C, I_LW, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_LW, 32'h5C, 32'h55, 32'h1234, 32'h4, 5'd9, 5'd8, 5'd0));
        vecs[9]  = v("indep_add", 32'h60, I_ADD7, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_R, 32'h60, 0, 32'h55, 32'h5020, 5'd7, 5'd9, 5'd10));
        vecs[10] = v("lw3", 32'h64, I_LW, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_LW, 32'h64, 32'h55, 32'h1234, 32'h4, 5'd9, 5'd8, 5'd0));
        vecs[11] = v("lw_lw_stall", 32'h68, I_LW, 0, 5'd0, 32'h0, 0, 1, '0);
        vecs[12] = v("lw_lw_release", 32'h68, I_LW, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_LW, 32'h68, 32'h55, 32'h1234, 32'h4, 5'd9, 5'd8, 5'd0));
        vecs[13] = v("lw_add_stall", 32'h6C, I_ADD, 0, 5'd0, 32'h0, 0, 1, '0);
        vecs[14] = v("lw_add_release", 32'h6C, I_ADD, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_R, 32'h6C, 32'h1234, 32'h55, 32'h5020, 5'd8, 5'd9, 5'd10));
        vecs[15] = v("lw4", 32'h70, I_LW, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_LW, 32'h70, 32'h55, 32'h1234, 32'h4, 5'd9, 5'd8, 5'd0));
        vecs[16] = v("flush_over_stall", 32'h74, I_ADD, 0, 5'd0, 32'h0, 1, 0, '0);
        vecs[17] = v("flush_nohaz", 32'h78, I_SW, 0, 5'd0, 32'h0, 1, 0, '0);
        vecs[18] = v("sw", 32'h78, I_SW, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_SW, 32'h78, 32'h55, 32'h1234, 32'h8, 5'd9, 5'd8, 5'd0));
        vecs[19] = v("beq", 32'h7C, I_BEQ, 0, 5'd0, 32'h0, 0, 0,
                     mk(C_BEQ, 32'h7C, 32'h1234, 32'h55, 32'h3, 5'd8, 5'd9, 5'd0));

        reset = 1'b1; IF_ID = '0; wb_reg_write = 0; wb_write_reg = '0;
        wb_write_data = '0; flush = 0;
        @(posedge clk); #1;
        chkw("reset_idex", ID_EX, '0);
        chk1("reset_stall", stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            IF_ID = vecs[i].if_id; wb_reg_write = vecs[i].wb_en;
            wb_write_reg = vecs[i].wb_reg; wb_write_data = vecs[i].wb_data;
            flush = vecs[i].flush;
            #1;
            chk1({vecs[i].name, "_stall"}, stall, vecs[i].exp_stall);
            @(posedge clk); #1;
            chkw({vecs[i].name, "_idex"}, ID_EX, vecs[i].exp_idex);
        end

        // Mid-stream reset with a live load-use hazard and non-zero ID_EX
        @(negedge clk);
        IF_ID = {32'h80, I_LW}; wb_reg_write = 0; flush = 0;
        @(posedge clk); #1;
        @(negedge clk);
        IF_ID = {32'h84, I_ADD};
        #1;
        chk1("pre_reset_stall", stall, 1'b1);
        reset = 1'b1;
        #1;
        chkw("async_reset_idex", ID_EX, '0);
        chk1("async_reset_stall", stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        IF_ID = {32'h88, I_ADD};
        #1;
        chk1("post_reset_stall", stall, 1'b0);
        @(posedge clk); #1;
        chkw("post_reset_regs_clear", ID_EX,
             mk(C_R, 32'h88, 0, 0, 32'h5020, 5'd8, 5'd9, 5'd10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
